// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and
// the fixed widths of an incoming sample and of the sample counter.
package sum_acc_pkg;

    // Sample is {cout, sum[2:0]} from the upstream adder
    localparam int SAMPLE_W = 4;
    // Wide enough to count up to 15 samples
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES 4-bit adder results ({cout, sum}) into an ACC_W-bit
// total with a sticky overflow flag. A batch closes after N_SAMPLES accepts
// or on flush; the result is then held with a valid/ready handshake until
// downstream takes it, while the input side is stalled.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         sum_in,
    input  logic               cout_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               ovf_out,
    output logic [CNT_W-1:0]   count_out
);

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

    state_t                state;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf;

    logic [SAMPLE_W-1:0]   sample;
    logic [ACC_W:0]        sum_ext;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  accept;

    // Datapath helpers: current sample, widened sum with carry, next count
    always_comb begin
        sample  = {cout_in, sum_in};
        sum_ext = {1'b0, acc} + (ACC_W + 1)'(sample);
        cnt_inc = cnt + CNT_W'(1);
        accept  = in_valid & in_ready;
    end

    // Batch FSM with registered handshake outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= ACC_W'(sample);
                        cnt <= CNT_W'(1);
                        ovf <= 1'b0;
                        if (N_SAMPLES == 1 || flush) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_ext[ACC_W-1:0];
                        ovf <= ovf | sum_ext[ACC_W];
                        cnt <= cnt_inc;
                        // A sample arriving with flush is folded in before closing
                        if (cnt_inc == N_LAST || flush) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result outputs read as zero whenever no result is being presented
    always_comb begin
        acc_out   = out_valid ? acc : '0;
        ovf_out   = out_valid ? ovf : 1'b0;
        count_out = out_valid ? cnt : '0;
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: three instances cover N=4/ACC_W=8,
// N=2/ACC_W=4 and N=1/ACC_W=8. Directed stimulus pushes hand-computed
// results; a negedge monitor pops and compares on each output handshake.
module tb_sum_accumulator;

    typedef struct {
        int acc;
        int ovf;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] iv, ir, fl, ov, ordy, ovf, cout_i;
    logic [2:0] sum_i [3];
    logic [3:0] cnt_o [3];
    logic [7:0] acc0, acc2;
    logic [3:0] acc1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    sum_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u_n4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .sum_in(sum_i[0]), .cout_in(cout_i[0]), .flush(fl[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .acc_out(acc0),
        .ovf_out(ovf[0]), .count_out(cnt_o[0]));

    sum_accumulator #(.N_SAMPLES(2), .ACC_W(4)) u_n2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .sum_in(sum_i[1]), .cout_in(cout_i[1]), .flush(fl[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .acc_out(acc1),
        .ovf_out(ovf[1]), .count_out(cnt_o[1]));

    sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .sum_in(sum_i[2]), .cout_in(cout_i[2]), .flush(fl[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .acc_out(acc2),
        .ovf_out(ovf[2]), .count_out(cnt_o[2]));

    function automatic int get_acc(input int k);
        case (k)
            0:       return int'(acc0);
            1:       return int'(acc1);
            default: return int'(acc2);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int k, input int a, input int o, input int c);
        exp_t e;
        e.acc = a; e.ovf = o; e.cnt = c;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one sample for one cycle; caller is aligned #1 after a posedge
    task automatic send(input int k, input int v, input logic f);
        chk($sformatf("in_ready_before_send%0d", k), int'(ir[k]), 1);
        iv[k]     = 1'b1;
        sum_i[k]  = 3'(v);
        cout_i[k] = 1'(v >> 3);
        fl[k]     = f;
        tick(1);
        iv[k] = 1'b0;
        fl[k] = 1'b0;
    endtask

    // Monitor one instance: compare on handshake, else expect zeroed outputs
    task automatic mon(input int k);
        exp_t e;
        logic hit;
        if (ov[k]) begin
            if (ordy[k]) begin
                hit = 1'b0;
                case (k)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); hit = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); hit = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); hit = 1'b1; end
                endcase
                if (!hit) begin
                    chk($sformatf("unexpected_result%0d", k), 1, 0);
                end else begin
                    chk($sformatf("acc_out%0d", k), get_acc(k), e.acc);
                    chk($sformatf("ovf_out%0d", k), int'(ovf[k]), e.ovf);
                    chk($sformatf("count_out%0d", k), int'(cnt_o[k]), e.cnt);
                end
            end
        end else begin
            chk($sformatf("idle_zero%0d", k),
                get_acc(k) + int'(ovf[k]) + int'(cnt_o[k]), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) mon(k);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        iv = '0; fl = '0; ordy = '1; cout_i = '0;
        for (int k = 0; k < 3; k++) sum_i[k] = '0;
        rst = 1'b0;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_out_valid%0d", k), int'(ov[k]), 0);
            chk($sformatf("reset_in_ready%0d", k), int'(ir[k]), 1);
        end
        rst = 1'b1;
        tick(1);

        // N=4: 3+5+7+15 = 30, result visible the cycle after the 4th accept
        push(0, 30, 0, 4);
        send(0, 3, 1'b0);
        send(0, 5, 1'b0);
        send(0, 7, 1'b0);
        chk("n4_not_early", int'(ov[0]), 0);
        send(0, 15, 1'b0);
        chk("n4_latency", int'(ov[0]), 1);
        tick(1);
        chk("n4_ready_after", int'(ir[0]), 1);

        // N=2, ACC_W=4: 15+15 = 30 -> 14 with carry out
        push(1, 14, 1, 2);
        send(1, 15, 1'b0);
        send(1, 15, 1'b0);
        chk("n2_valid", int'(ov[1]), 1);
        tick(1);

        // Backpressure: 1+2+3+4 = 10 held for 5 cycles, input pulses ignored
        ordy[0] = 1'b0;
        push(0, 10, 0, 4);
        for (int i = 1; i <= 4; i++) send(0, i, 1'b0);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1; sum_i[0] = 3'd5; cout_i[0] = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", int'(ir[0]), 0);
            chk("bp_valid", int'(ov[0]), 1);
            chk("bp_acc", get_acc(0), 10);
            chk("bp_cnt", int'(cnt_o[0]), 4);
            tick(1);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick(1);
        chk("bp_released", int'(ov[0]), 0);
        push(0, 8, 0, 4);
        for (int i = 0; i < 4; i++) send(0, 2, 1'b0);
        tick(1);

        // Flush in IDLE with no sample is ignored
        fl[0] = 1'b1;
        tick(1);
        fl[0] = 1'b0;
        chk("idle_flush_ignored", int'(ov[0]), 0);

        // Flush after 6,9 with no sample closes with 15, count 2
        push(0, 15, 0, 2);
        send(0, 6, 1'b0);
        send(0, 9, 1'b0);
        fl[0] = 1'b1;
        tick(1);
        fl[0] = 1'b0;
        chk("flush_valid", int'(ov[0]), 1);
        tick(1);

        // Flush with an accept in IDLE closes a one-sample batch
        push(0, 7, 0, 1);
        send(0, 7, 1'b1);
        chk("idle_flush_accept", int'(ov[0]), 1);
        tick(1);

        // Reset mid-batch discards the partial sum
        send(0, 1, 1'b0);
        send(0, 1, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("midrst_valid", int'(ov[0]), 0);
        chk("midrst_ready", int'(ir[0]), 1);
        rst = 1'b1;
        push(0, 4, 0, 4);
        for (int i = 0; i < 4; i++) send(0, 1, 1'b0);
        tick(1);

        // N=1: each sample of 9 is its own result
        for (int i = 0; i < 3; i++) begin
            push(2, 9, 0, 1);
            send(2, 9, 1'b0);
            chk("n1_valid", int'(ov[2]), 1);
            tick(1);
        end

        tick(3);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
